// File: rtl/seq_signed_multiplier.sv
// Iterative shift-and-add multiplier that retires STEP multiplier bits per cycle.
// Signed operands are converted to magnitudes and the product sign is applied afterwards.
module seq_signed_multiplier #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW    = 2 * WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] SIGN = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    generate
        if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_params
            $error("seq_signed_multiplier: WIDTH must be >= 2 and a multiple of STEP");
        end
    endgenerate

    logic [1:0]       state_q,  state_d;
    logic [PW-1:0]    mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q,    acc_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             sign_q,   sign_d;
    logic [PW-1:0]    result_q, result_d;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [STEP-1:0]  digit;
    logic [PW-1:0]    partial;

    // Negating -2^(WIDTH-1) wraps back to itself, which read unsigned is exactly 2^(WIDTH-1).
    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // The multiplicand register is pre-shifted to the current bit offset each iteration.
    assign digit   = mplier_q[STEP-1:0];
    assign partial = mcand_q * PW'(digit);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

    always_comb begin
        // NOTE: every next-state signal defaults to its register so no path leaves it unassigned (no latch).
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = CALC;
                    mcand_d  = PW'(a_mag);
                    mplier_d = b_mag;
                    sign_d   = a_neg ^ b_neg;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            CALC: begin
                acc_d    = acc_q + partial;
                mplier_d = mplier_q >> STEP;
                mcand_d  = mcand_q << STEP;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                result_d = sign_q ? -acc_q : acc_q;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Directed and randomized checks of seq_signed_multiplier at WIDTH=8 with STEP=1 and STEP=4.
module tb_seq_signed_multiplier;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid8, in_valid4;
    logic [7:0]  a, b;
    logic        is_signed;
    logic        out_ready;
    logic        in_ready8, in_ready4;
    logic        out_valid8, out_valid4;
    logic [15:0] result8, result4;

    int          checks = 0;
    int          errors = 0;
    logic        sel;
    logic [15:0] last8, last4;

    always #5 clock = ~clock;

    seq_signed_multiplier #(.WIDTH(8), .STEP(1)) dut8 (
        .clock(clock), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid8),
        .out_ready(out_ready), .result(result8)
    );

    seq_signed_multiplier #(.WIDTH(8), .STEP(4)) dut4 (
        .clock(clock), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid4),
        .out_ready(out_ready), .result(result4)
    );

    logic        cur_in_ready, cur_out_valid;
    logic [15:0] cur_result;
    assign cur_in_ready  = sel ? in_ready4  : in_ready8;
    assign cur_out_valid = sel ? out_valid4 : out_valid8;
    assign cur_result    = sel ? result4    : result8;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        if (sel) in_valid4 = v;
        else     in_valid8 = v;
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic signed [15:0] sx, sy;
        if (s) begin
            sx = {{8{x[7]}}, x};
            sy = {{8{y[7]}}, y};
            return sx * sy;
        end
        return {8'h00, x} * {8'h00, y};
    endfunction

    // Starts at a negedge with the selected DUT idle; ends at a negedge with it idle again.
    task automatic run_txn(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic sv, input logic [15:0] expv, input int hold,
                           input logic toggle);
        int          n;
        logic [15:0] prev;
        n    = sel ? 2 : 8;
        prev = sel ? last4 : last8;
        chk({tag, "_ready_before"}, 64'(cur_in_ready), 64'(1));
        a = av; b = bv; is_signed = sv;
        set_valid(1'b1);
        @(negedge clock);
        set_valid(1'b0);
        chk({tag, "_ready_after_accept"}, 64'(cur_in_ready), 64'(0));
        for (int i = 1; i <= n; i++) begin
            if (toggle) begin
                a = 8'($urandom);
                b = 8'($urandom);
                is_signed = 1'($urandom);
                set_valid(1'($urandom));
            end
            @(negedge clock);
            chk({tag, "_valid_early"}, 64'(cur_out_valid), 64'(0));
            chk({tag, "_ready_busy"}, 64'(cur_in_ready), 64'(0));
            chk({tag, "_result_held"}, 64'(cur_result), 64'(prev));
        end
        @(negedge clock);
        chk({tag, "_valid"}, 64'(cur_out_valid), 64'(1));
        chk({tag, "_result"}, 64'(cur_result), 64'(expv));
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(negedge clock);
            chk({tag, "_hold_valid"}, 64'(cur_out_valid), 64'(1));
            chk({tag, "_hold_result"}, 64'(cur_result), 64'(expv));
            chk({tag, "_hold_ready"}, 64'(cur_in_ready), 64'(0));
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        set_valid(1'b0);
        chk({tag, "_release_valid"}, 64'(cur_out_valid), 64'(0));
        chk({tag, "_release_ready"}, 64'(cur_in_ready), 64'(1));
        chk({tag, "_idle_result"}, 64'(cur_result), 64'(expv));
        if (sel) last4 = expv;
        else     last8 = expv;
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rs;
        sel = 1'b0;
        reset = 1'b1;
        in_valid8 = 1'b0; in_valid4 = 1'b0;
        a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b0;
        last8 = '0; last4 = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        chk("rst_in_ready8", 64'(in_ready8), 64'(1));
        chk("rst_out_valid8", 64'(out_valid8), 64'(0));
        chk("rst_result8", 64'(result8), 64'(0));
        chk("rst_in_ready4", 64'(in_ready4), 64'(1));
        chk("rst_out_valid4", 64'(out_valid4), 64'(0));
        chk("rst_result4", 64'(result4), 64'(0));

        // STEP=1 directed vectors
        run_txn("s_m3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1, 0, 1'b1);
        run_txn("s_m128sq", 8'h80, 8'h80, 1'b1, 16'h4000, 0, 1'b0);
        run_txn("u_ffxff", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, 1'b1);
        run_txn("s_hold5", 8'h7F, 8'h81, 1'b1, 16'hC0FF, 5, 1'b1);

        // reset while the counter sits at iteration 4
        a = 8'hFD; b = 8'h05; is_signed = 1'b1;
        in_valid8 = 1'b1;
        @(negedge clock);
        in_valid8 = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midcalc_rst_valid", 64'(out_valid8), 64'(0));
        chk("midcalc_rst_result", 64'(result8), 64'(0));
        chk("midcalc_rst_ready", 64'(in_ready8), 64'(1));
        last8 = 16'h0000;
        run_txn("s_7xm6", 8'h07, 8'hFA, 1'b1, 16'hFFD6, 0, 1'b0);

        // reset wins over a simultaneous accept
        a = 8'h12; b = 8'h34; is_signed = 1'b0;
        in_valid8 = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        in_valid8 = 1'b0;
        chk("rst_prio_ready", 64'(in_ready8), 64'(1));
        chk("rst_prio_result", 64'(result8), 64'(0));
        @(negedge clock);
        chk("rst_prio_still_idle", 64'(in_ready8), 64'(1));
        last8 = 16'h0000;

        // STEP=4 directed vectors
        sel = 1'b1;
        run_txn("s4_m1xm1", 8'hFF, 8'hFF, 1'b1, 16'h0001, 0, 1'b1);
        run_txn("s4_0xm128", 8'h00, 8'h80, 1'b1, 16'h0000, 0, 1'b0);
        run_txn("u4_ffx80", 8'hFF, 8'h80, 1'b0, 16'h7F80, 2, 1'b1);

        // randomized back-to-back traffic on both configurations
        for (int d = 0; d < 2; d++) begin
            sel = (d == 1);
            for (int t = 0; t < 12; t++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rs = 1'($urandom);
                run_txn(sel ? "rand4" : "rand8", ra, rb, rs, ref_mul(ra, rb, rs), t % 3, 1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
